branch_pred_unit: RTL and testbench

Parametrised tournament branch predictor for the pipelined RV32I core.
- Combines a PC-indexed local 2-bit BHT, a gshare 2-bit PHT (PC xor global history) and a 2-bit chooser table, plus a direct-mapped tagged BTB.
- Queried by IF with the fetch PC; trained by EX with resolved branch/jump outcomes; restores global history on misprediction.
- Replaces the fixed-size local BHT and BTB pair with one configurable unit.

---
 rtl/branch_pred_unit_pkg.sv | 34 +++
 rtl/branch_pred_unit_sat_counter_table.sv | 38 +++
 rtl/branch_pred_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_branch_pred_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_unit_pkg.sv
// Shared constants and helpers for the tournament branch predictor.
// Contents:
//   CTR_WEAK_NT  - init value of every 2-bit counter (weakly not-taken / weakly-local)
//   StInit/StRun - predictor FSM encodings
//   sat_update() - 2-bit saturating counter step
//   max3()       - widest of three index widths (sizes the init sweep)
// Width-dependent types (bpu_meta_t, btb_entry_t) live in branch_pred_unit because
// their field widths follow that module's parameters.
package branch_pred_unit_pkg;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    nxt = ctr;
    if (up) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/branch_pred_unit_sat_counter_table.sv
// sat_counter_table: array of 2^IdxW two-bit saturating counters.
// Ports:
//   clk_i                 - clock
//   init_en_i/init_idx_i  - force one entry to CTR_WEAK_NT (takes priority over update)
//   rd_idx_i/rd_ctr_o     - read port; value is sampled by the owner at the next edge,
//                           so a same-cycle update is not visible (read-before-write)
//   upd_en_i/upd_idx_i/upd_up_i - saturating step of one entry toward upd_up_i
// No reset: contents are established by the owner's init sweep.
module sat_counter_table
  import branch_pred_unit_pkg::*;
#(
  parameter int unsigned IdxW = 10
) (
  input  logic            clk_i,
  input  logic            init_en_i,
  input  logic [IdxW-1:0] init_idx_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic [1:0]      rd_ctr_o,
  input  logic            upd_en_i,
  input  logic [IdxW-1:0] upd_idx_i,
  input  logic            upd_up_i
);

  localparam int unsigned Depth = 1 << IdxW;

  logic [1:0] mem_q [Depth];

  assign rd_ctr_o = mem_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (init_en_i) begin
      mem_q[init_idx_i] <= CTR_WEAK_NT;
    end else if (upd_en_i) begin
      mem_q[upd_idx_i] <= sat_update(mem_q[upd_idx_i], upd_up_i);
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: tournament branch predictor (local BHT + gshare PHT + chooser) with a
// direct-mapped tagged BTB and speculative global history.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   ready_o               - init sweep finished; predictions valid
//   pred_req_i/pred_pc_i  - fetch query; results registered one cycle later on
//                           pred_taken_o/pred_target_o/pred_meta_o ({ghr, local, global})
//   res_*_i               - resolved control-flow outcome from EX, with its pred_meta
//   stat_predictions_o/stat_correct_o - resolved-branch / correct-prediction counters
// Optional build macro BPU_STATS_EN: instantiates the statistics counters; otherwise both
// stat outputs are tied to zero.
module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 10,
  parameter int unsigned GHR_W     = 10,
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned BTB_TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready_o,
  input  logic             pred_req_i,
  input  logic [31:0]      pred_pc_i,
  output logic             pred_taken_o,
  output logic [31:0]      pred_target_o,
  output logic [GHR_W+1:0] pred_meta_o,
  input  logic             res_valid_i,
  input  logic [31:0]      res_pc_i,
  input  logic             res_is_jump_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  input  logic [GHR_W+1:0] res_meta_i,
  input  logic             res_mispredict_i,
  output logic [31:0]      stat_predictions_o,
  output logic [31:0]      stat_correct_o
);

  typedef struct packed {
    logic [GHR_W-1:0] ghr;
    logic             local_dir;
    logic             global_dir;
  } bpu_meta_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [29:0]          target;
    logic                 is_jump;
  } btb_entry_t;

  localparam int unsigned SweepW   = max3(BHT_IDX_W, GHR_W, BTB_IDX_W);
  localparam int unsigned BtbDepth = 1 << BTB_IDX_W;

  logic [0:0]        state_q, state_d;
  logic [SweepW-1:0] sweep_q, sweep_d;
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic              pred_taken_q, pred_taken_d;
  logic [31:0]       pred_target_q, pred_target_d;
  logic [GHR_W+1:0]  pred_meta_q, pred_meta_d;

  logic in_init, in_run, pred_fire, res_fire, res_branch;
  logic bht_init_en, pht_init_en, btb_init_en;

  assign in_init    = (state_q == StInit);
  assign in_run     = (state_q == StRun);
  assign pred_fire  = pred_req_i && in_run;
  assign res_fire   = res_valid_i && in_run;
  assign res_branch = res_fire && !res_is_jump_i;

  // The sweep spans the largest table; smaller tables only take in-range indices.
  assign bht_init_en = in_init && ((sweep_q >> BHT_IDX_W) == '0);
  assign pht_init_en = in_init && ((sweep_q >> GHR_W) == '0);
  assign btb_init_en = in_init && ((sweep_q >> BTB_IDX_W) == '0);

  // ---------------- predict-side lookup ----------------
  logic [BHT_IDX_W-1:0] p_bht_idx;
  logic [GHR_W-1:0]     p_pht_idx;
  logic [BTB_IDX_W-1:0] p_btb_idx;
  logic [BTB_TAG_W-1:0] p_tag;
  logic [1:0]           bht_ctr, pht_ctr, cho_ctr;
  btb_entry_t           btb_rd;
  logic                 p_hit, p_dir;

  assign p_bht_idx = pred_pc_i[BHT_IDX_W+1:2];
  assign p_pht_idx = pred_pc_i[GHR_W+1:2] ^ ghr_q;
  assign p_btb_idx = pred_pc_i[BTB_IDX_W+1:2];
  assign p_tag     = pred_pc_i[BTB_IDX_W+2 +: BTB_TAG_W];

  // ---------------- resolve-side update ----------------
  bpu_meta_t            r_meta;
  logic [BHT_IDX_W-1:0] r_bht_idx;
  logic [GHR_W-1:0]     r_pht_idx;
  logic [BTB_IDX_W-1:0] r_btb_idx;
  logic                 cho_upd_en, cho_up;

  assign r_meta     = res_meta_i;
  assign r_bht_idx  = res_pc_i[BHT_IDX_W+1:2];
  // gshare index must use the history the prediction was made with, not the live ghr.
  assign r_pht_idx  = res_pc_i[GHR_W+1:2] ^ r_meta.ghr;
  assign r_btb_idx  = res_pc_i[BTB_IDX_W+1:2];
  assign cho_upd_en = res_branch && (r_meta.local_dir != r_meta.global_dir);
  assign cho_up     = (r_meta.global_dir == res_taken_i);

  sat_counter_table #(.IdxW(BHT_IDX_W)) u_bht (
    .clk_i      (clk),
    .init_en_i  (bht_init_en),
    .init_idx_i (sweep_q[BHT_IDX_W-1:0]),
    .rd_idx_i   (p_bht_idx),
    .rd_ctr_o   (bht_ctr),
    .upd_en_i   (res_branch),
    .upd_idx_i  (r_bht_idx),
    .upd_up_i   (res_taken_i)
  );

  sat_counter_table #(.IdxW(GHR_W)) u_pht (
    .clk_i      (clk),
    .init_en_i  (pht_init_en),
    .init_idx_i (sweep_q[GHR_W-1:0]),
    .rd_idx_i   (p_pht_idx),
    .rd_ctr_o   (pht_ctr),
    .upd_en_i   (res_branch),
    .upd_idx_i  (r_pht_idx),
    .upd_up_i   (res_taken_i)
  );

  // Chooser shares the BHT index; counter MSB set means "trust gshare".
  sat_counter_table #(.IdxW(BHT_IDX_W)) u_chooser (
    .clk_i      (clk),
    .init_en_i  (bht_init_en),
    .init_idx_i (sweep_q[BHT_IDX_W-1:0]),
    .rd_idx_i   (p_bht_idx),
    .rd_ctr_o   (cho_ctr),
    .upd_en_i   (cho_upd_en),
    .upd_idx_i  (r_bht_idx),
    .upd_up_i   (cho_up)
  );

  btb_entry_t btb_q [BtbDepth];

  assign btb_rd = btb_q[p_btb_idx];
  assign p_hit  = btb_rd.valid && (btb_rd.tag == p_tag);
  assign p_dir  = btb_rd.is_jump ? 1'b1 : (cho_ctr[1] ? pht_ctr[1] : bht_ctr[1]);

  always_ff @(posedge clk) begin
    if (btb_init_en) begin
      btb_q[sweep_q[BTB_IDX_W-1:0]] <= '0;
    end else if (res_fire && res_taken_i) begin
      btb_q[r_btb_idx] <= '{valid:   1'b1,
                            tag:     res_pc_i[BTB_IDX_W+2 +: BTB_TAG_W],
                            target:  res_target_i[31:2],
                            is_jump: res_is_jump_i};
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    ghr_d         = ghr_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    pred_meta_d   = pred_meta_q;

    if (in_init) begin
      sweep_d = sweep_q + {{(SweepW-1){1'b0}}, 1'b1};
      if (&sweep_q) state_d = StRun;
    end

    if (pred_fire) begin
      pred_taken_d  = p_hit && p_dir;
      pred_target_d = (p_hit && p_dir) ? {btb_rd.target, 2'b00} : pred_pc_i + 32'd4;
      pred_meta_d   = {ghr_q, bht_ctr[1], pht_ctr[1]};
      if (p_hit && !btb_rd.is_jump) ghr_d = {ghr_q[GHR_W-2:0], p_dir};
    end

    // Misprediction repair wins over a same-cycle speculative shift.
    if (res_fire && res_mispredict_i) begin
      ghr_d = res_is_jump_i ? r_meta.ghr : {r_meta.ghr[GHR_W-2:0], res_taken_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInit;
      sweep_q       <= '0;
      ghr_q         <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_meta_q   <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      ghr_q         <= ghr_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_meta_q   <= pred_meta_d;
    end
  end

  assign ready_o       = in_run;
  assign pred_taken_o  = pred_taken_q;
  assign pred_target_o = pred_target_q;
  assign pred_meta_o   = pred_meta_q;

`ifdef BPU_STATS_EN
  logic [31:0] stat_pred_q, stat_corr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pred_q <= '0;
      stat_corr_q <= '0;
    end else if (res_branch) begin
      stat_pred_q <= stat_pred_q + 32'd1;
      if (!res_mispredict_i) stat_corr_q <= stat_corr_q + 32'd1;
    end
  end

  assign stat_predictions_o = stat_pred_q;
  assign stat_correct_o     = stat_corr_q;
`else
  assign stat_predictions_o = '0;
  assign stat_correct_o     = '0;
`endif

  // Address bits outside the index/tag fields and the byte offset of targets are unused.
  logic unused_bits;
  assign unused_bits = ^{res_pc_i, res_target_i[1:0]};

endmodule

// File: tb/tb_branch_pred_unit.sv
module tb_branch_pred_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready_o;
  logic        pred_req_i;
  logic [31:0] pred_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic [11:0] pred_meta_o;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic        res_is_jump_i;
  logic        res_taken_i;
  logic [31:0] res_target_i;
  logic [11:0] res_meta_i;
  logic        res_mispredict_i;
  logic [31:0] stat_predictions_o;
  logic [31:0] stat_correct_o;

  always #5 clk = ~clk;

  branch_pred_unit u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ready_o            (ready_o),
    .pred_req_i         (pred_req_i),
    .pred_pc_i          (pred_pc_i),
    .pred_taken_o       (pred_taken_o),
    .pred_target_o      (pred_target_o),
    .pred_meta_o        (pred_meta_o),
    .res_valid_i        (res_valid_i),
    .res_pc_i           (res_pc_i),
    .res_is_jump_i      (res_is_jump_i),
    .res_taken_i        (res_taken_i),
    .res_target_i       (res_target_i),
    .res_meta_i         (res_meta_i),
    .res_mispredict_i   (res_mispredict_i),
    .stat_predictions_o (stat_predictions_o),
    .stat_correct_o     (stat_correct_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        chk;
    logic        taken;
    logic [31:0] target;
    logic        chk_ghr;
    logic [9:0]  ghr;
  } exp_t;

  exp_t sb[$];

  // Queue the expected prediction, then drive a one-cycle request; on return the
  // registered result is on the outputs.
  task automatic drive_pred(input logic [31:0] pc, input logic chk, input logic tk,
                            input logic [31:0] tgt, input logic chk_g, input logic [9:0] g);
    exp_t e;
    e.chk = chk; e.taken = tk; e.target = tgt; e.chk_ghr = chk_g; e.ghr = g;
    @(negedge clk);
    pred_req_i = 1'b1;
    pred_pc_i  = pc;
    sb.push_back(e);
    @(negedge clk);
    pred_req_i = 1'b0;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic jmp, input logic tk,
                           input logic [31:0] tgt, input logic [11:0] meta, input logic mp);
    @(negedge clk);
    res_valid_i = 1'b1; res_pc_i = pc; res_is_jump_i = jmp; res_taken_i = tk;
    res_target_i = tgt; res_meta_i = meta; res_mispredict_i = mp;
    @(negedge clk);
    res_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    pred_req_i = 1'b0; pred_pc_i = '0;
    res_valid_i = 1'b0; res_pc_i = '0; res_is_jump_i = 1'b0; res_taken_i = 1'b0;
    res_target_i = '0; res_meta_i = '0; res_mispredict_i = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %0b want 0", ready_o); end
    n_cmp++; if (pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %0b want 0", pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'h0) begin n_bad++; $display("FAIL reset_target: got %h want 0", pred_target_o); end
    n_cmp++; if (pred_meta_o !== 12'h0) begin n_bad++; $display("FAIL reset_meta: got %h want 0", pred_meta_o); end
    n_cmp++; if (stat_predictions_o !== 32'h0 || stat_correct_o !== 32'h0) begin
      n_bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_predictions_o, stat_correct_o);
    end
    // Requests and resolves during INIT must have no effect.
    pred_req_i = 1'b1; pred_pc_i = 32'h60;
    res_valid_i = 1'b1; res_pc_i = 32'h60; res_taken_i = 1'b1; res_target_i = 32'h99c;
    res_meta_i = 12'hffc; res_mispredict_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1023) @(negedge clk);
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL init_len_early: ready=%0b want 0 after 1023 cycles", ready_o); end
    @(negedge clk);
    pred_req_i = 1'b0; res_valid_i = 1'b0; res_mispredict_i = 1'b0;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL init_len: ready=%0b want 1 after 1024 cycles", ready_o); end
    n_cmp++; if (pred_target_o !== 32'h0 || pred_taken_o !== 1'b0) begin
      n_bad++; $display("FAIL init_ignores_req: taken=%0b target=%h want 0/0", pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_first_predict;
    exp_t e;
    drive_pred(32'h60, 1'b1, 1'b0, 32'h64, 1'b1, 10'h000);
    e = sb.pop_front();
    n_cmp++; if (pred_taken_o !== e.taken) begin n_bad++; $display("FAIL first_taken: got %0b want %0b", pred_taken_o, e.taken); end
    n_cmp++; if (pred_target_o !== e.target) begin n_bad++; $display("FAIL first_target: got %h want %h", pred_target_o, e.target); end
    n_cmp++; if (pred_meta_o[11:2] !== e.ghr) begin n_bad++; $display("FAIL first_ghr: got %h want %h", pred_meta_o[11:2], e.ghr); end
  endtask

  task automatic test_taken_branch;
    exp_t e;
    drive_res(32'h100, 1'b0, 1'b1, 32'h80, {10'h000, 2'b00}, 1'b1);
    drive_res(32'h100, 1'b0, 1'b1, 32'h80, {10'h001, 2'b00}, 1'b1);
    drive_pred(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 10'h003);
    e = sb.pop_front();
    n_cmp++; if (pred_taken_o !== e.taken) begin n_bad++; $display("FAIL branch_taken: got %0b want %0b", pred_taken_o, e.taken); end
    n_cmp++; if (pred_target_o !== e.target) begin n_bad++; $display("FAIL branch_target: got %h want %h", pred_target_o, e.target); end
    n_cmp++; if (pred_meta_o[11:2] !== e.ghr) begin n_bad++; $display("FAIL branch_ghr: got %h want %h", pred_meta_o[11:2], e.ghr); end
  endtask

  task automatic test_jump;
    exp_t e;
    logic [31:0] pcs [2];
    logic [31:0] tgts [2];
    logic        tks [2];
    pcs[0] = 32'h200; tgts[0] = 32'h400; tks[0] = 1'b1;
    pcs[1] = 32'h60;  tgts[1] = 32'h64;  tks[1] = 1'b0;
    // ghr after the previous speculative shift is 0x007; a jump must leave it alone.
    drive_res(32'h200, 1'b1, 1'b1, 32'h400, {10'h007, 2'b00}, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive_pred(pcs[i], 1'b1, tks[i], tgts[i], 1'b1, 10'h007);
      e = sb.pop_front();
      n_cmp++; if (pred_taken_o !== e.taken) begin n_bad++; $display("FAIL jump_taken[%0d]: got %0b want %0b", i, pred_taken_o, e.taken); end
      n_cmp++; if (pred_target_o !== e.target) begin n_bad++; $display("FAIL jump_target[%0d]: got %h want %h", i, pred_target_o, e.target); end
      n_cmp++; if (pred_meta_o[11:2] !== e.ghr) begin n_bad++; $display("FAIL jump_ghr[%0d]: got %h want %h", i, pred_meta_o[11:2], e.ghr); end
    end
  endtask

  task automatic test_mispredict_override;
    exp_t e;
    drive_res(32'h140, 1'b0, 1'b1, 32'h180, {10'h007, 2'b00}, 1'b1);
    // Speculative shift (hit on 0x140) and mispredict repair in the same cycle.
    e.chk = 1'b1; e.taken = 1'b1; e.target = 32'h180; e.chk_ghr = 1'b1; e.ghr = 10'h00f;
    @(negedge clk);
    pred_req_i = 1'b1; pred_pc_i = 32'h140;
    res_valid_i = 1'b1; res_pc_i = 32'h500; res_is_jump_i = 1'b0; res_taken_i = 1'b1;
    res_target_i = 32'h520; res_meta_i = {10'h155, 2'b00}; res_mispredict_i = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    pred_req_i = 1'b0; res_valid_i = 1'b0; res_mispredict_i = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (pred_taken_o !== e.taken) begin n_bad++; $display("FAIL override_taken: got %0b want %0b", pred_taken_o, e.taken); end
    n_cmp++; if (pred_meta_o[11:2] !== e.ghr) begin n_bad++; $display("FAIL override_meta_pre: got %h want %h", pred_meta_o[11:2], e.ghr); end
    drive_pred(32'h60, 1'b1, 1'b0, 32'h64, 1'b1, 10'h2ab);
    e = sb.pop_front();
    n_cmp++; if (pred_meta_o[11:2] !== e.ghr) begin n_bad++; $display("FAIL override_ghr: got %h want %h", pred_meta_o[11:2], e.ghr); end
    n_cmp++; if (pred_target_o !== e.target) begin n_bad++; $display("FAIL override_target: got %h want %h", pred_target_o, e.target); end
  endtask

  task automatic test_read_before_write;
    exp_t e;
    e.chk = 1'b1; e.taken = 1'b0; e.target = 32'h404; e.chk_ghr = 1'b0; e.ghr = '0;
    @(negedge clk);
    pred_req_i = 1'b1; pred_pc_i = 32'h400;
    res_valid_i = 1'b1; res_pc_i = 32'h400; res_is_jump_i = 1'b0; res_taken_i = 1'b1;
    res_target_i = 32'h440; res_meta_i = {10'h2ab, 2'b00}; res_mispredict_i = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    pred_req_i = 1'b0; res_valid_i = 1'b0; res_mispredict_i = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (pred_taken_o !== e.taken || pred_target_o !== e.target) begin
      n_bad++; $display("FAIL rbw_same_cycle: got %0b/%h want %0b/%h", pred_taken_o, pred_target_o, e.taken, e.target);
    end
    drive_pred(32'h400, 1'b1, 1'b1, 32'h440, 1'b0, 10'h000);
    e = sb.pop_front();
    n_cmp++; if (pred_taken_o !== e.taken || pred_target_o !== e.target) begin
      n_bad++; $display("FAIL rbw_after: got %0b/%h want %0b/%h", pred_taken_o, pred_target_o, e.taken, e.target);
    end
  endtask

  task automatic test_loop;
    exp_t        e;
    logic        act;
    logic        mp;
    logic [11:0] meta;
    for (int rep = 0; rep < 20; rep++) begin
      for (int k = 0; k < 4; k++) begin
        act = (k != 3);
        drive_pred(32'h300, (rep >= 18), act, act ? 32'h2f0 : 32'h304, 1'b0, 10'h000);
        e = sb.pop_front();
        if (e.chk) begin
          n_cmp++; if (pred_taken_o !== e.taken || pred_target_o !== e.target) begin
            n_bad++; $display("FAIL loop[%0d.%0d]: got %0b/%h want %0b/%h", rep, k, pred_taken_o, pred_target_o, e.taken, e.target);
          end
        end
        if (rep == 19 && k == 3) begin
          // Local still says taken on the exit; gshare must be the one chosen.
          n_cmp++; if (pred_meta_o[1:0] !== 2'b10) begin
            n_bad++; $display("FAIL loop_chooser: local/global=%b want 10", pred_meta_o[1:0]);
          end
        end
        mp   = (pred_taken_o != act) || (act && pred_target_o != 32'h2f0);
        meta = pred_meta_o;
        drive_res(32'h300, 1'b0, act, 32'h2f0, meta, mp);
      end
    end
  endtask

  task automatic test_reset_midrun;
    exp_t e;
    int   waited;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL midrun_ready: got %0b want 0", ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    waited = 0;
    while (ready_o !== 1'b1 && waited < 1100) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL midrun_reinit_timeout: ready=%0b want 1", ready_o); end
    drive_pred(32'h300, 1'b1, 1'b0, 32'h304, 1'b1, 10'h000);
    e = sb.pop_front();
    n_cmp++; if (pred_taken_o !== e.taken || pred_target_o !== e.target) begin
      n_bad++; $display("FAIL midrun_forgot: got %0b/%h want %0b/%h", pred_taken_o, pred_target_o, e.taken, e.target);
    end
    n_cmp++; if (pred_meta_o[11:2] !== e.ghr) begin n_bad++; $display("FAIL midrun_ghr: got %h want %h", pred_meta_o[11:2], e.ghr); end
  endtask

  task automatic test_stats;
    for (int i = 0; i < 10; i++) begin
      drive_res(32'h700 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 12'h000, (i < 3));
    end
    drive_res(32'h800, 1'b1, 1'b1, 32'h900, 12'h000, 1'b1);
`ifdef BPU_STATS_EN
    n_cmp++; if (stat_predictions_o !== 32'd10) begin n_bad++; $display("FAIL stat_predictions: got %0d want 10", stat_predictions_o); end
    n_cmp++; if (stat_correct_o !== 32'd7) begin n_bad++; $display("FAIL stat_correct: got %0d want 7", stat_correct_o); end
`else
    n_cmp++; if (stat_predictions_o !== 32'd0) begin n_bad++; $display("FAIL stat_predictions_off: got %0d want 0", stat_predictions_o); end
    n_cmp++; if (stat_correct_o !== 32'd0) begin n_bad++; $display("FAIL stat_correct_off: got %0d want 0", stat_correct_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_predict();
    test_taken_branch();
    test_jump();
    test_mispredict_override();
    test_read_before_write();
    test_loop();
    test_reset_midrun();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
